// File: rtl/cordic_arb_pkg.sv
// Shared types and helpers for CORDIC pipeline sharing.
// tag_t   : {vld, id} travelling alongside a CORDIC operation.
// state_t : hold/drain FSM states.
// rr_pick : round-robin one-hot grant starting one past ptr.
// The tag id field is sized for the largest supported requester count (16);
// users keep only the low $clog2(NREQ) bits.
package cordic_arb_pkg;

  localparam int unsigned ARB_MAX_REQ = 16;
  localparam int unsigned ARB_ID_W    = 4;

  typedef struct packed {
    logic                vld;
    logic [ARB_ID_W-1:0] id;
  } tag_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    HELD  = 2'd2
  } state_t;

  // Scan valid from ptr+1 upward, wrapping modulo nreq; first set bit wins.
  function automatic logic [ARB_MAX_REQ-1:0] rr_pick(
    input logic [ARB_MAX_REQ-1:0] valid,
    input logic [ARB_ID_W-1:0]    ptr,
    input int unsigned            nreq
  );
    logic [ARB_MAX_REQ-1:0] grant;
    logic                   found;
    logic [ARB_ID_W-1:0]    idx;
    grant = '0;
    found = 1'b0;
    for (int unsigned k = 1; k <= ARB_MAX_REQ; k++) begin
      idx = ARB_ID_W'((32'(ptr) + k) % nreq);
      if ((k <= nreq) && !found && valid[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
    return grant;
  endfunction

endpackage

// File: rtl/cordic_arb_tagpipe.sv
// LAT-deep shift register of tag_t, delaying each tag to line up with the
// result of the CORDIC operation it describes.
// Ports: clk, reset (async, active-high), tag_in, tag_out (= tag_in delayed LAT clocks).
module cordic_arb_tagpipe
  import cordic_arb_pkg::*;
#(
  parameter int unsigned LAT = 10
) (
  input  logic clk,
  input  logic reset,
  input  tag_t tag_in,
  output tag_t tag_out
);

  tag_t pipe_q [LAT];
  tag_t pipe_d [LAT];

  // Shift one stage per clock
  always_comb begin
    pipe_d[0] = tag_in;
    for (int unsigned i = 1; i < LAT; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  assign tag_out = pipe_q[LAT-1];

endmodule

// File: rtl/cordic_mp_arbiter.sv
// Round-robin sharing of one fixed-latency magnitude/phase CORDIC among NREQ
// requesters, with an id tag pipeline routing results back and a hold/drain FSM.
// Optional feature macro: CORDIC_ARB_STATS_EN adds per-requester accept counters
// (stat_cnt out, stat_clr in).
// Ports:
//   clk, reset                    clock, async active-high reset
//   req_valid/req_ready           per-requester handshake (ready one-hot or zero)
//   req_x/req_y                   packed signed operands, XY_WIDTH each
//   cor_st/cor_xin/cor_yin        issue to CORDIC
//   cor_rdy/cor_mag/cor_ph        result from CORDIC
//   res_valid/res_id/res_mag/res_ph  routed result strobe
//   hold/hold_ack                 quiesce request / pipeline empty
//   err                           sticky tag vs. cor_rdy mismatch
module cordic_mp_arbiter
  import cordic_arb_pkg::*;
#(
  parameter  int unsigned NREQ     = 4,
  parameter  int unsigned N        = 8,
  parameter  int unsigned XY_WIDTH = 12,
  parameter  int unsigned LAT      = N + 2,
  localparam int unsigned ID_W     = $clog2(NREQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*XY_WIDTH-1:0] req_x,
  input  logic [NREQ*XY_WIDTH-1:0] req_y,
  output logic                     cor_st,
  output logic [XY_WIDTH-1:0]      cor_xin,
  output logic [XY_WIDTH-1:0]      cor_yin,
  input  logic                     cor_rdy,
  input  logic [XY_WIDTH-1:0]      cor_mag,
  input  logic [XY_WIDTH+1:0]      cor_ph,
  output logic                     res_valid,
  output logic [ID_W-1:0]          res_id,
  output logic [XY_WIDTH-1:0]      res_mag,
  output logic [XY_WIDTH+1:0]      res_ph,
  input  logic                     hold,
  output logic                     hold_ack,
  output logic                     err
`ifdef CORDIC_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0]       stat_cnt,
  input  logic                     stat_clr
`endif
);

  localparam int unsigned CNT_W = $clog2(LAT + 2);

  state_t               state_q, state_d;
  logic [ID_W-1:0]      ptr_q, ptr_d;
  logic                 cor_st_q, cor_st_d;
  logic [XY_WIDTH-1:0]  xin_q, xin_d, yin_q, yin_d;
  logic [ID_W-1:0]      iss_id_q, iss_id_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 res_valid_q, res_valid_d;
  logic [ID_W-1:0]      res_id_q, res_id_d;
  logic [XY_WIDTH-1:0]  res_mag_q, res_mag_d;
  logic [XY_WIDTH+1:0]  res_ph_q, res_ph_d;
  logic                 err_q, err_d;
  logic                 hold_ack_q, hold_ack_d;

  logic [ARB_MAX_REQ-1:0] pick_c;
  logic [NREQ-1:0]        grant_c;
  logic [ID_W-1:0]        win_c;
  logic                   fire_c;
  tag_t                   tag_in, tag_out;

  // Arbitration: depends only on req_valid, ptr and state
  always_comb begin
    pick_c  = rr_pick(ARB_MAX_REQ'(req_valid), ARB_ID_W'(ptr_q), NREQ);
    grant_c = (state_q == RUN) ? pick_c[NREQ-1:0] : '0;
    win_c   = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_c[i]) win_c = ID_W'(i);
    end
    fire_c  = |(req_valid & grant_c);
  end

  // Pick bits above NREQ and tag id bits above ID_W are structurally zero
  if (NREQ < ARB_MAX_REQ) begin : g_pick_pad
    logic unused_pick;
    assign unused_pick = |pick_c[ARB_MAX_REQ-1:NREQ];
  end
  if (ID_W < ARB_ID_W) begin : g_id_pad
    logic unused_id;
    assign unused_id = |tag_out.id[ARB_ID_W-1:ID_W];
  end

  // Issue, result capture, in-flight count and FSM next state
  always_comb begin
    ptr_d       = ptr_q;
    cor_st_d    = fire_c;
    xin_d       = xin_q;
    yin_d       = yin_q;
    iss_id_d    = iss_id_q;
    cnt_d       = cnt_q;
    res_valid_d = cor_rdy & tag_out.vld;
    res_id_d    = res_id_q;
    res_mag_d   = res_mag_q;
    res_ph_d    = res_ph_q;
    err_d       = err_q | (cor_rdy != tag_out.vld);
    state_d     = state_q;

    if (fire_c) begin
      ptr_d    = win_c;
      xin_d    = req_x[32'(win_c) * XY_WIDTH +: XY_WIDTH];
      yin_d    = req_y[32'(win_c) * XY_WIDTH +: XY_WIDTH];
      iss_id_d = win_c;
    end

    if (res_valid_d) begin
      res_id_d  = ID_W'(tag_out.id);
      res_mag_d = cor_mag;
      res_ph_d  = cor_ph;
    end

    // Simultaneous issue and retire leaves the count unchanged
    case ({cor_st_q, tag_out.vld})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    case (state_q)
      RUN:   if (hold) state_d = DRAIN;
      // Empty once nothing is counted, nothing is entering and no tag is retiring
      DRAIN: if (!hold) state_d = RUN;
             else if ((cnt_q == '0) && !cor_st_q && !tag_out.vld) state_d = HELD;
      HELD:  if (!hold) state_d = RUN;
      default: state_d = RUN;
    endcase

    hold_ack_d = (state_d == HELD);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      ptr_q       <= ID_W'(NREQ - 1);
      cor_st_q    <= 1'b0;
      xin_q       <= '0;
      yin_q       <= '0;
      iss_id_q    <= '0;
      cnt_q       <= '0;
      res_valid_q <= 1'b0;
      res_id_q    <= '0;
      res_mag_q   <= '0;
      res_ph_q    <= '0;
      err_q       <= 1'b0;
      hold_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      cor_st_q    <= cor_st_d;
      xin_q       <= xin_d;
      yin_q       <= yin_d;
      iss_id_q    <= iss_id_d;
      cnt_q       <= cnt_d;
      res_valid_q <= res_valid_d;
      res_id_q    <= res_id_d;
      res_mag_q   <= res_mag_d;
      res_ph_q    <= res_ph_d;
      err_q       <= err_d;
      hold_ack_q  <= hold_ack_d;
    end
  end

  // Tag enters alongside cor_st and leaves aligned with cor_rdy
  always_comb begin
    tag_in     = '0;
    tag_in.vld = cor_st_q;
    tag_in.id  = ARB_ID_W'(iss_id_q);
  end

  cordic_arb_tagpipe #(.LAT(LAT)) u_tagpipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  assign req_ready = grant_c;
  assign cor_st    = cor_st_q;
  assign cor_xin   = xin_q;
  assign cor_yin   = yin_q;
  assign res_valid = res_valid_q;
  assign res_id    = res_id_q;
  assign res_mag   = res_mag_q;
  assign res_ph    = res_ph_q;
  assign err       = err_q;
  assign hold_ack  = hold_ack_q;

`ifdef CORDIC_ARB_STATS_EN
  logic [15:0] stat_q [NREQ];
  logic [15:0] stat_d [NREQ];

  // Saturating per-requester accept counters
  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_d[i] = stat_q[i];
      if (stat_clr) begin
        stat_d[i] = '0;
      end else if (req_valid[i] && grant_c[i] && (stat_q[i] != 16'hFFFF)) begin
        stat_d[i] = stat_q[i] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        stat_q[i] <= '0;
      end
    end else begin
      stat_q <= stat_d;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      stat_cnt[i*16 +: 16] = stat_q[i];
    end
  end
`endif

endmodule
